// File: rtl/iq_mult_post.sv
// iq_mult_post: two-arm fixed-point post-multiplier for the BPSK receive path.
// A flag-qualified ADC sample is multiplied by both NCO references. Each
// product then goes through PIPE register stages. Finally it is rounded,
// sliced to OUT_W bits and saturated. An overflow event counter tracks
// samples in which either arm left the output range.
// All state changes on the falling edge of clk. Reset is asynchronous.
module iq_mult_post #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 32,
   parameter int SHIFT = 20,
   parameter int PIPE  = 2,
   parameter int ROUND = 1,
   parameter int SAT   = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flag_in,
   input  logic [IN_W-1:0]  adc,
   input  logic [IN_W-1:0]  i_ref,
   input  logic [IN_W-1:0]  q_ref,
   input  logic             ovf_clr,
   output logic [OUT_W-1:0] i_out,
   output logic [OUT_W-1:0] q_out,
   output logic             flag_out,
   output logic [CNT_W-1:0] ovf_cnt
);

   // Full product width, and one guard bit so the rounding add cannot wrap.
   localparam int PW      = 2 * IN_W;
   localparam int RW      = PW + 1;
   // MSB of the output slice; every bit from here up must agree for no overflow.
   localparam int TOP     = SHIFT + OUT_W - 1;
   localparam int UW      = RW - TOP;
   localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [RW-1:0]    RND_INC = (ROUND != 0 && SHIFT > 0) ? (RW'(1) << RND_POS) : '0;
   localparam logic [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] MAX_NEG = {1'b1, {(OUT_W-1){1'b0}}};

   // Input registers
   logic [IN_W-1:0]  adc_q;
   logic [IN_W-1:0]  i_ref_q;
   logic [IN_W-1:0]  q_ref_q;
   logic             vin_q;

   // Product pipeline
   logic [PW-1:0]    i_prod_d;
   logic [PW-1:0]    q_prod_d;
   logic [PW-1:0]    i_pipe_q [PIPE];
   logic [PW-1:0]    q_pipe_q [PIPE];
   logic             v_pipe_q [PIPE];

   // Post-processing per arm (index 0 = I, 1 = Q)
   logic [1:0][PW-1:0]    arm_prod;
   logic [1:0][OUT_W:0]   arm_post;
   logic [1:0][OUT_W-1:0] arm_res;
   logic [1:0]            arm_ovf;

   // Output stage
   logic [OUT_W-1:0] i_out_q, i_out_d;
   logic [OUT_W-1:0] q_out_q, q_out_d;
   logic             flag_q,  flag_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   // Round, detect overflow and slice/saturate one product.
   // The result is returned as {overflow, value}.
   function automatic logic [OUT_W:0] post_proc(input logic [PW-1:0] prod);
      logic [RW-1:0]    r;
      logic [UW-1:0]    upper;
      logic             ovf;
      logic [OUT_W-1:0] res;
      r     = {prod[PW-1], prod} + RND_INC;
      upper = r[RW-1:TOP];
      ovf   = !((&upper) || !(|upper));
      res   = r[TOP:SHIFT];
      if (SAT != 0 && ovf) begin
         res = r[RW-1] ? MAX_NEG : MAX_POS;
      end
      return {ovf, res};
   endfunction

   // Capture a sample and its valid bit. The data holds when no sample is offered.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         adc_q   <= '0;
         i_ref_q <= '0;
         q_ref_q <= '0;
         vin_q   <= 1'b0;
      end else begin
         vin_q <= flag_in;
         if (flag_in) begin
            adc_q   <= adc;
            i_ref_q <= i_ref;
            q_ref_q <= q_ref;
         end
      end
   end

   // Signed products. The operands are sign-extended to full width, so the
   // low PW bits of the unsigned multiply form the two's-complement product.
   assign i_prod_d = {{IN_W{adc_q[IN_W-1]}}, adc_q} * {{IN_W{i_ref_q[IN_W-1]}}, i_ref_q};
   assign q_prod_d = {{IN_W{adc_q[IN_W-1]}}, adc_q} * {{IN_W{q_ref_q[IN_W-1]}}, q_ref_q};

   // Free-running product pipeline. It has no stall; the valid bits travel with the data.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < PIPE; s++) begin
            i_pipe_q[s] <= '0;
            q_pipe_q[s] <= '0;
            v_pipe_q[s] <= 1'b0;
         end
      end else begin
         i_pipe_q[0] <= i_prod_d;
         q_pipe_q[0] <= q_prod_d;
         v_pipe_q[0] <= vin_q;
         for (int s = 1; s < PIPE; s++) begin
            i_pipe_q[s] <= i_pipe_q[s-1];
            q_pipe_q[s] <= q_pipe_q[s-1];
            v_pipe_q[s] <= v_pipe_q[s-1];
         end
      end
   end

   assign arm_prod[0] = i_pipe_q[PIPE-1];
   assign arm_prod[1] = q_pipe_q[PIPE-1];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_arm
         assign arm_post[gi] = post_proc(arm_prod[gi]);
         assign arm_ovf[gi]  = arm_post[gi][OUT_W];
         assign arm_res[gi]  = arm_post[gi][OUT_W-1:0];
      end
   endgenerate

   // Output load, strobe and saturating overflow counter. Clear beats increment.
   always_comb begin
      i_out_d = i_out_q;
      q_out_d = q_out_q;
      flag_d  = 1'b0;
      cnt_d   = cnt_q;
      if (v_pipe_q[PIPE-1]) begin
         i_out_d = arm_res[0];
         q_out_d = arm_res[1];
         flag_d  = 1'b1;
         if ((|arm_ovf) && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      if (ovf_clr) begin
         cnt_d = '0;
      end
   end

   // Output stage registers
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         i_out_q <= '0;
         q_out_q <= '0;
         flag_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         i_out_q <= i_out_d;
         q_out_q <= q_out_d;
         flag_q  <= flag_d;
         cnt_q   <= cnt_d;
      end
   end

   assign i_out    = i_out_q;
   assign q_out    = q_out_q;
   assign flag_out = flag_q;
   assign ovf_cnt  = cnt_q;

endmodule

// File: tb/tb_iq_mult_post.sv
// Directed testbench for iq_mult_post. Four instances share one stimulus:
// the defaults, a wrapping variant (SAT=0), a truncating variant (ROUND=0)
// and a 2-bit counter variant (CNT_W=2).
module tb_iq_mult_post;

   localparam int LAT = 3;   // PIPE(2) + 1 falling edges from capture to strobe

   logic        clk;
   logic        reset;
   logic        flag_in;
   logic [31:0] adc, i_ref, q_ref;
   logic        ovf_clr;

   logic [31:0] i_out, q_out;
   logic        flag_out;
   logic [15:0] ovf_cnt;

   logic [31:0] w_i_out, w_q_out;
   logic        w_flag_out;
   logic [15:0] w_ovf_cnt;

   logic [31:0] t_i_out, t_q_out;
   logic        t_flag_out;
   logic [15:0] t_ovf_cnt;

   logic [31:0] c_i_out, c_q_out;
   logic        c_flag_out;
   logic [1:0]  c_ovf_cnt;

   int checks = 0;
   int errors = 0;

   iq_mult_post dut (
      .clk(clk), .reset(reset), .flag_in(flag_in), .adc(adc), .i_ref(i_ref),
      .q_ref(q_ref), .ovf_clr(ovf_clr), .i_out(i_out), .q_out(q_out),
      .flag_out(flag_out), .ovf_cnt(ovf_cnt)
   );

   iq_mult_post #(.SAT(0)) dut_wrap (
      .clk(clk), .reset(reset), .flag_in(flag_in), .adc(adc), .i_ref(i_ref),
      .q_ref(q_ref), .ovf_clr(ovf_clr), .i_out(w_i_out), .q_out(w_q_out),
      .flag_out(w_flag_out), .ovf_cnt(w_ovf_cnt)
   );

   iq_mult_post #(.ROUND(0)) dut_trunc (
      .clk(clk), .reset(reset), .flag_in(flag_in), .adc(adc), .i_ref(i_ref),
      .q_ref(q_ref), .ovf_clr(ovf_clr), .i_out(t_i_out), .q_out(t_q_out),
      .flag_out(t_flag_out), .ovf_cnt(t_ovf_cnt)
   );

   iq_mult_post #(.CNT_W(2)) dut_c2 (
      .clk(clk), .reset(reset), .flag_in(flag_in), .adc(adc), .i_ref(i_ref),
      .q_ref(q_ref), .ovf_clr(ovf_clr), .i_out(c_i_out), .q_out(c_q_out),
      .flag_out(c_flag_out), .ovf_cnt(c_ovf_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Apply inputs, let one falling edge pass, and settle 1 time unit.
   task automatic drive(input logic f, input logic [31:0] a, input logic [31:0] i,
                        input logic [31:0] q, input logic clr);
      flag_in = f;
      adc     = a;
      i_ref   = i;
      q_ref   = q;
      ovf_clr = clr;
      @(negedge clk);
      #1;
   endtask

   // No sample offered; the data pins carry junk that must not be captured.
   task automatic idle();
      drive(1'b0, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'h3C3C_3C3C, 1'b0);
   endtask

   task automatic wait_lat();
      repeat (LAT) idle();
   endtask

   logic [7:0]  pat;
   logic [31:0] exp_i, exp_q;
   logic        exp_f;

   initial begin
      pat     = 8'b1011_1011;   // bit t = flag_in at step t: 1,1,0,1,1,1,0,1
      reset   = 1'b1;
      flag_in = 1'b0;
      adc     = '0;
      i_ref   = '0;
      q_ref   = '0;
      ovf_clr = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_i_out", i_out, 0);
      chk("rst_q_out", q_out, 0);
      chk("rst_flag", flag_out, 0);
      chk("rst_cnt", ovf_cnt, 0);
      reset = 1'b0;
      idle();

      // Latency / basic: 1.0 * 0.5 and 1.0 * -0.5
      drive(1'b1, 32'h0100_0000, 32'h0080_0000, 32'hFF80_0000, 1'b0);
      for (int c = 1; c < LAT; c++) begin
         idle();
         chk("lat_early_flag", flag_out, 0);
      end
      idle();
      chk("lat_flag", flag_out, 1);
      chk("lat_i_out", i_out, 32'h0800_0000);
      chk("lat_q_out", q_out, 32'hF800_0000);
      chk("lat_cnt", ovf_cnt, 0);
      idle();
      chk("lat_one_shot", flag_out, 0);
      chk("lat_i_hold", i_out, 32'h0800_0000);

      // Positive saturation on the I arm
      drive(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0);
      wait_lat();
      chk("satp_flag", flag_out, 1);
      chk("satp_i_out", i_out, 32'h7FFF_FFFF);
      chk("satp_q_out", q_out, 32'h0000_0000);
      chk("satp_cnt", ovf_cnt, 1);
      chk("wrapp_i_out", w_i_out, 32'hFFFF_F000);
      chk("wrapp_cnt", w_ovf_cnt, 1);
      drive(1'b0, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'h3C3C_3C3C, 1'b1);
      chk("clr_cnt", ovf_cnt, 0);
      chk("clr_wrap_cnt", w_ovf_cnt, 0);

      // Negative saturation on the Q arm
      drive(1'b1, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0);
      wait_lat();
      chk("satn_q_out", q_out, 32'h8000_0000);
      chk("satn_i_out", i_out, 32'h0000_0000);
      chk("satn_cnt", ovf_cnt, 1);
      chk("wrapn_q_out", w_q_out, 32'h0000_0800);
      chk("wrapn_cnt", w_ovf_cnt, 1);

      // Rounding: 2^19 rounds up, 2^19-1 rounds down, truncation drops both
      drive(1'b1, 32'h0000_0001, 32'h0008_0000, 32'h0007_FFFF, 1'b0);
      wait_lat();
      chk("rnd_up_i", i_out, 32'h0000_0001);
      chk("rnd_down_q", q_out, 32'h0000_0000);
      chk("trunc_i", t_i_out, 32'h0000_0000);
      chk("trunc_q", t_q_out, 32'h0000_0000);
      chk("rnd_cnt", ovf_cnt, 1);

      // Streaming with gaps: sample j carries adc=j+1, refs +/-2^20,
      // so the outputs are +(j+1) and -(j+1).
      exp_i = 32'h0000_0001;
      exp_q = 32'h0000_0000;
      for (int t = 0; t < 8 + LAT + 1; t++) begin
         if (t < 8 && pat[t]) begin
            drive(1'b1, 32'(t + 1), 32'h0010_0000, 32'hFFF0_0000, 1'b0);
         end else begin
            idle();
         end
         exp_f = 1'b0;
         if (t >= LAT && t - LAT < 8) begin
            if (pat[t-LAT]) begin
               exp_f = 1'b1;
               exp_i = 32'(t - LAT + 1);
               exp_q = 32'h0 - 32'(t - LAT + 1);
            end
         end
         chk("strm_flag", flag_out, exp_f);
         chk("strm_i_out", i_out, exp_i);
         chk("strm_q_out", q_out, exp_q);
      end

      // Reset with two samples in flight
      drive(1'b1, 32'h0100_0000, 32'h0080_0000, 32'h0000_0000, 1'b0);
      drive(1'b1, 32'h0100_0000, 32'h0100_0000, 32'h0000_0000, 1'b0);
      flag_in = 1'b0;
      reset   = 1'b1;
      #1;
      chk("mrst_i_out", i_out, 0);
      chk("mrst_q_out", q_out, 0);
      chk("mrst_flag", flag_out, 0);
      chk("mrst_cnt", ovf_cnt, 0);
      @(negedge clk);
      #1;
      reset = 1'b0;
      for (int c = 0; c < LAT + 1; c++) begin
         idle();
         chk("mrst_no_flag", flag_out, 0);
         chk("mrst_i_zero", i_out, 0);
      end
      drive(1'b1, 32'h0100_0000, 32'h0080_0000, 32'hFF80_0000, 1'b0);
      for (int c = 1; c < LAT; c++) begin
         idle();
         chk("mrst_early_flag", flag_out, 0);
      end
      idle();
      chk("mrst_lat_flag", flag_out, 1);
      chk("mrst_lat_i_out", i_out, 32'h0800_0000);

      // Counter saturation: five overflowing samples
      for (int n = 0; n < 5; n++) begin
         drive(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
      end
      wait_lat();
      chk("cnt_five", ovf_cnt, 5);
      chk("cnt_c2_stick", c_ovf_cnt, 3);
      chk("cnt_c2_i_out", c_i_out, 32'h7FFF_FFFF);

      // Clear on the same edge as an overflow increment
      drive(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0);
      repeat (LAT - 1) idle();
      drive(1'b0, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 32'h3C3C_3C3C, 1'b1);
      chk("clrwin_flag", flag_out, 1);
      chk("clrwin_cnt", ovf_cnt, 0);
      chk("clrwin_c2_flag", c_flag_out, 1);
      chk("clrwin_c2_cnt", c_ovf_cnt, 0);
      idle();
      chk("clrwin_after", ovf_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
